// File: rtl/soc_gpio_ctrl.sv
// Purpose: register-mapped GPIO peripheral with per-pin output enable, atomic set/clear,
//          synchronised inputs and a sticky, maskable edge interrupt.
// Latency: grant is combinational; rvalid/rdata follow one cycle after each granted request.
//          A pad edge reaches DIN after SYNC_STAGES cycles and STATUS after SYNC_STAGES+1.
// Backpressure: none. Every request is granted in the cycle it is presented, and
//               back-to-back requests get one response per cycle.
//
// Ports:
//   clk, rst_n         - clock and asynchronous active-low reset
//   req/we/addr/wdata  - bus request; addr[4:2] selects the register, addr[1:0] is ignored
//   gnt/rvalid/rdata   - grant (= req), response valid, read data (0 on writes and when idle)
//   gpio_dout/gpio_oe  - pad output values and output enables, driven straight from flops
//   gpio_din           - asynchronous pad inputs
//   irq                - registered OR of all sticky STATUS flags

module soc_gpio_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             we,
    input  logic [4:0]       addr,
    input  logic [31:0]      wdata,
    output logic             gnt,
    output logic             rvalid,
    output logic [31:0]      rdata,
    output logic [WIDTH-1:0] gpio_dout,
    output logic [WIDTH-1:0] gpio_oe,
    input  logic [WIDTH-1:0] gpio_din,
    output logic             irq
);

    localparam logic [2:0] REG_DOUT    = 3'd0;
    localparam logic [2:0] REG_DIN     = 3'd1;
    localparam logic [2:0] REG_OE      = 3'd2;
    localparam logic [2:0] REG_RISE_IE = 3'd3;
    localparam logic [2:0] REG_FALL_IE = 3'd4;
    localparam logic [2:0] REG_STATUS  = 3'd5;
    localparam logic [2:0] REG_SET     = 3'd6;
    localparam logic [2:0] REG_CLR     = 3'd7;

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] rise_ie_q;
    logic [WIDTH-1:0] fall_ie_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] prev_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic             irq_q;

    logic [2:0]       reg_sel;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rd_val;
    logic [31:0]      rd_word;

    // Byte-lane bits of the address and the upper write-data bits beyond WIDTH carry no meaning.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};

    assign reg_sel = addr[4:2];
    assign wr_en   = req & we;
    assign rd_en   = req & ~we;
    assign wd      = wdata[WIDTH-1:0];

    assign gnt       = req;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign gpio_dout = dout_q;
    assign gpio_oe   = oe_q;
    assign irq       = irq_q;

    // Input synchroniser and edge history
    assign sync_in  = sync_q[SYNC_STAGES-1];
    assign rise     = sync_in & ~prev_q;
    assign fall     = ~sync_in & prev_q;
    assign edge_set = (rise & rise_ie_q) | (fall & fall_ie_q);
    assign w1c      = (wr_en && reg_sel == REG_STATUS) ? wd : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_in;
        end
    end

    // Edge set is ORed in after the clear, so an edge in the same cycle as a W1C wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= edge_set | (status_q & ~w1c);
            irq_q    <= |status_q;
        end
    end

    // Control register writes; SET/CLR act on the current DOUT value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q    <= '0;
            oe_q      <= '0;
            rise_ie_q <= '0;
            fall_ie_q <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                REG_DOUT:    dout_q    <= wd;
                REG_OE:      oe_q      <= wd;
                REG_RISE_IE: rise_ie_q <= wd;
                REG_FALL_IE: fall_ie_q <= wd;
                REG_SET:     dout_q    <= dout_q | wd;
                REG_CLR:     dout_q    <= dout_q & ~wd;
                default:     ;
            endcase
        end
    end

    // Read mux sees pre-edge register values, so a read returns the value before any
    // same-cycle update.
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_DOUT:    rd_val = dout_q;
            REG_DIN:     rd_val = sync_in;
            REG_OE:      rd_val = oe_q;
            REG_RISE_IE: rd_val = rise_ie_q;
            REG_FALL_IE: rd_val = fall_ie_q;
            REG_STATUS:  rd_val = status_q;
            default:     rd_val = '0;
        endcase
        rd_word = '0;
        rd_word[WIDTH-1:0] = rd_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= req;
            rdata_q  <= rd_en ? rd_word : 32'h0;
        end
    end

endmodule

// File: tb/tb_soc_gpio_ctrl.sv
// Purpose: directed scoreboard bench for soc_gpio_ctrl (WIDTH=8, SYNC_STAGES=2).
// Latency: each request pushes its expected rdata and issue cycle; the monitor expects it next cycle.
// Backpressure: none; requests may be issued back-to-back.

module tb_soc_gpio_ctrl;

    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [4:0]    addr;
    logic [31:0]   wdata;
    logic          gnt;
    logic          rvalid;
    logic [31:0]   rdata;
    logic [W-1:0]  gpio_dout;
    logic [W-1:0]  gpio_oe;
    logic [W-1:0]  gpio_din;
    logic          irq;

    int checks;
    int errors;
    int cyc;

    typedef struct {
        logic [31:0] dat;
        int          issued;
    } exp_t;

    exp_t sb_q[$];

    soc_gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .gpio_dout (gpio_dout),
        .gpio_oe   (gpio_oe),
        .gpio_din  (gpio_din),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: consume one scoreboard entry per rvalid, flag missing or unexpected responses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h expected no response (cycle %0d)",
                             rdata, cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rdata", rdata, e.dat);
                    chk("rvalid_latency", 32'(cyc - e.issued), 32'd1);
                end
            end else begin
                chk("rdata_idle", rdata, 32'h0);
                if (sb_q.size() != 0 && cyc > sb_q[0].issued + 1) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_rvalid: got rvalid=0 expected response %h (cycle %0d)", e.dat, cyc);
                end
            end
        end
    end

    // Issue one request in the current cycle; returns just after the granting edge.
    task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [31:0] exp);
        exp_t e;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        e.dat    = w ? 32'h0 : exp;
        e.issued = cyc;
        sb_q.push_back(e);
        #1;
        chk("gnt", {31'h0, gnt}, 32'h1);
        @(posedge clk);
        #1;
        req   = 1'b0;
        we    = 1'b0;
        wdata = 32'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        req      = 1'b0;
        we       = 1'b0;
        addr     = 5'h0;
        wdata    = 32'h0;
        gpio_din = '0;

        // Reset state
        #12;
        chk("rst_gnt", {31'h0, gnt}, 32'h0);
        chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rst_dout", 32'(gpio_dout), 32'h0);
        chk("rst_oe", 32'(gpio_oe), 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            bus(1'b0, 5'(i * 4), 32'h0, 32'h0);
        end
        idle(1);
        chk("gnt_idle", {31'h0, gnt}, 32'h0);
        chk("irq_after_rst", {31'h0, irq}, 32'h0);

        // Outputs and atomic set/clear
        bus(1'b1, 5'h00, 32'h0000_00F0, 32'h0);
        chk("dout_write", 32'(gpio_dout), 32'hF0);
        bus(1'b1, 5'h18, 32'h0000_000F, 32'h0);
        chk("dout_set", 32'(gpio_dout), 32'hFF);
        bus(1'b1, 5'h1C, 32'h0000_0030, 32'h0);
        chk("dout_clr", 32'(gpio_dout), 32'hCF);
        bus(1'b0, 5'h00, 32'h0, 32'h0000_00CF);
        bus(1'b0, 5'h18, 32'h0, 32'h0);
        bus(1'b0, 5'h1C, 32'h0, 32'h0);
        bus(1'b1, 5'h0B, 32'h0000_00A5, 32'h0);   // addr[1:0] ignored
        chk("oe_write", 32'(gpio_oe), 32'hA5);
        bus(1'b0, 5'h08, 32'h0, 32'h0000_00A5);
        bus(1'b1, 5'h04, 32'h0000_00FF, 32'h0);   // DIN is read-only
        bus(1'b0, 5'h04, 32'h0, 32'h0);

        // Input synchroniser latency and rising-edge flag
        bus(1'b1, 5'h0C, 32'h0000_0008, 32'h0);
        gpio_din[3] = 1'b1;                       // cycle t
        bus(1'b0, 5'h04, 32'h0, 32'h0);           // t
        bus(1'b0, 5'h04, 32'h0, 32'h0);           // t+1
        bus(1'b0, 5'h04, 32'h0, 32'h0000_0008);   // t+2
        chk("irq_t3", {31'h0, irq}, 32'h0);
        bus(1'b0, 5'h14, 32'h0, 32'h0000_0008);   // t+3
        chk("irq_t4", {31'h0, irq}, 32'h1);
        bus(1'b1, 5'h14, 32'h0000_0008, 32'h0);
        idle(2);
        chk("irq_cleared", {31'h0, irq}, 32'h0);
        bus(1'b1, 5'h0C, 32'h0, 32'h0);

        // Edge masking
        bus(1'b1, 5'h10, 32'h0000_0001, 32'h0);
        gpio_din[0] = 1'b1;
        idle(4);
        bus(1'b0, 5'h14, 32'h0, 32'h0);
        gpio_din[0] = 1'b0;
        idle(4);
        bus(1'b0, 5'h14, 32'h0, 32'h0000_0001);
        chk("irq_fall", {31'h0, irq}, 32'h1);
        bus(1'b0, 5'h10, 32'h0, 32'h0000_0001);
        bus(1'b1, 5'h14, 32'h0000_0001, 32'h0);
        bus(1'b1, 5'h10, 32'h0, 32'h0);
        idle(2);
        chk("irq_fall_clr", {31'h0, irq}, 32'h0);
        gpio_din[0] = 1'b1;
        idle(4);
        gpio_din[0] = 1'b0;
        idle(4);
        bus(1'b0, 5'h14, 32'h0, 32'h0);
        chk("irq_masked", {31'h0, irq}, 32'h0);

        // W1C racing a new enabled edge
        bus(1'b1, 5'h0C, 32'h0000_0020, 32'h0);
        gpio_din[5] = 1'b1;
        idle(4);
        gpio_din[5] = 1'b0;
        idle(4);
        chk("irq_bit5", {31'h0, irq}, 32'h1);
        gpio_din[5] = 1'b1;                       // rise visible two cycles later
        idle(2);
        bus(1'b1, 5'h14, 32'h0000_0020, 32'h0);   // same cycle as the rise
        bus(1'b0, 5'h14, 32'h0, 32'h0000_0020);
        chk("irq_race", {31'h0, irq}, 32'h1);
        bus(1'b1, 5'h14, 32'h0000_0020, 32'h0);
        chk("irq_lag", {31'h0, irq}, 32'h1);
        bus(1'b0, 5'h14, 32'h0, 32'h0);
        chk("irq_drop", {31'h0, irq}, 32'h0);

        // Width truncation
        bus(1'b1, 5'h00, 32'hFFFF_FFFF, 32'h0);
        chk("dout_width", 32'(gpio_dout), 32'hFF);
        bus(1'b0, 5'h00, 32'h0, 32'h0000_00FF);
        bus(1'b1, 5'h0C, 32'hFFFF_FFFF, 32'h0);
        bus(1'b0, 5'h0C, 32'h0, 32'h0000_00FF);
        idle(1);

        // Reset abort of an in-flight read
        req  = 1'b1;
        we   = 1'b0;
        addr = 5'h00;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_dout", 32'(gpio_dout), 32'h0);
        chk("abort_oe", 32'(gpio_oe), 32'h0);
        chk("abort_rvalid", {31'h0, rvalid}, 32'h0);
        req = 1'b0;
        idle(2);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(4);
        chk("post_dout", 32'(gpio_dout), 32'h0);
        chk("post_oe", 32'(gpio_oe), 32'h0);
        chk("post_irq", {31'h0, irq}, 32'h0);
        bus(1'b0, 5'h00, 32'h0, 32'h0);
        bus(1'b0, 5'h0C, 32'h0, 32'h0);
        idle(3);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_gpio_ctrl.md
Name: soc_gpio_ctrl

Overview:
Parametrised GPIO controller that replaces the bare dout/din GPIO bus with a register-mapped peripheral on the SoC data bus. It provides per-pin output enable, atomic set/clear of outputs, a metastability-safe input synchroniser, and edge detection with a maskable, sticky interrupt. It sits between the core's peripheral bus decoder and the pad ring; its IRQ line goes to the core's fast interrupt input.

Parameters:
WIDTH, 32, number of GPIO pins (1..32); register bits [31:WIDTH] read 0 and ignore writes.
SYNC_STAGES, 2, flops in each input synchroniser chain (>=2).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  1  bus request
we  input  1  write enable (1 = write)
addr  input  5  byte address, bits [4:2] select the register, bits [1:0] ignored
wdata  input  32  write data
gnt  output  1  request grant
rvalid  output  1  response valid
rdata  output  32  read data
gpio_dout  output  WIDTH  pad output values
gpio_oe  output  WIDTH  pad output enables (1 = drive)
gpio_din  input  WIDTH  asynchronous pad inputs
irq  output  1  level interrupt request

Behaviour:
- Reset (rst_n low, asynchronous): every register, synchroniser flop and edge-history flop clears to 0. gnt=0, rvalid=0, rdata=0, gpio_dout=0, gpio_oe=0, irq=0. Reset asserted mid-transaction aborts it: no rvalid follows after release.
- Bus handshake:
  - gnt = req, combinational; every request is accepted in the cycle it is presented.
  - rvalid is asserted exactly 1 cycle after each granted request, reads and writes alike.
  - rdata is valid only while rvalid=1, and is 0 otherwise and for writes.
  - Back-to-back requests are supported, with one response per cycle.
- Register map (word offset : name : access):
  - 0x00 DOUT : RW.
  - 0x04 DIN : RO; returns the synchronised input. Writes are ignored.
  - 0x08 OE : RW.
  - 0x0C RISE_IE : RW.
  - 0x10 FALL_IE : RW.
  - 0x14 STATUS : read returns the sticky edge flags; writing 1 clears the corresponding flag (W1C).
  - 0x18 SET : writing ORs wdata into DOUT; reads 0.
  - 0x1C CLR : writing clears the DOUT bits where wdata is 1; reads 0.
- Register writes take effect on the clock edge that grants them. gpio_dout and gpio_oe are driven directly from the DOUT and OE flops.
- Read data is sampled on the grant edge, so a read returns the pre-write value of any register written in that same cycle by other logic.
- Input path:
  - gpio_din passes through a SYNC_STAGES flop chain, giving sync_in.
  - prev_in is sync_in delayed by 1 cycle.
  - rise = sync_in & ~prev_in; fall = ~sync_in & prev_in.
  - Pin latency: a pad transition is visible in DIN after SYNC_STAGES cycles and sets STATUS after SYNC_STAGES+1 cycles.
- STATUS update per bit i:
  - set if (rise[i] & RISE_IE[i]) | (fall[i] & FALL_IE[i]);
  - otherwise cleared if a STATUS write has wdata[i]=1;
  - otherwise held.
  - When an edge and a W1C hit the same cycle, the edge wins.
  - With both IE bits set for a pin, both edges set the flag.
  - Clearing an IE bit does not clear an already-set flag.
- irq = |STATUS, registered; it updates 1 cycle after STATUS changes.
- There is no loopback: DIN always reflects the pads, regardless of OE.

Test Plan:
- Reset values: after rst_n release, read all 8 offsets -> every read returns 0, rvalid arrives 1 cycle after each req, gnt=req in the same cycle, gpio_dout=0, gpio_oe=0, irq=0.
- Output and atomic ops: write DOUT=0x0000_00F0, SET wdata=0x0000_000F, CLR wdata=0x0000_0030, then read DOUT -> rdata=0x0000_00CF; gpio_dout follows each write on the granting edge; reads of SET and CLR return 0.
- Input sync latency: drive gpio_din[3] 0->1 at cycle t -> DIN bit 3 reads 1 for reads granted at or after t+SYNC_STAGES; with RISE_IE=0x8, STATUS=0x8 at t+3 and irq=1 at t+4 (SYNC_STAGES=2).
- Edge masking: RISE_IE=0, FALL_IE=0x1; toggle gpio_din[0] 0->1->0 -> only the falling edge sets STATUS bit 0; with FALL_IE=0, no flag and irq stays 0.
- W1C race: hold STATUS bit 5 set, then in the same cycle issue a STATUS write with wdata=0x20 and present a new enabled rising edge on bit 5 -> STATUS bit 5 stays 1 and irq stays 1; a second W1C with no edge present clears it and irq drops 1 cycle later.
- Width and reset abort: with WIDTH=8, write 0xFFFF_FFFF to DOUT -> reads 0x0000_00FF; issue a read and pull rst_n low before the next edge -> no rvalid follows after release, and all outputs are 0.
